m_shiftsequencer: RTL and testbench
===================================

M_SHIFTSEQUENCER -- requirements
Module: m_shiftsequencer

Interface
REQ-001 SHALL have parameter W, default 5: shift counter width, legal range 2..8.
REQ-002 SHALL have parameter COARSE, default 4: coarse step size; must be a power of two, 1..2^(W-1); 1 disables coarse stepping in effect.
REQ-003 SHALL have parameter LOADSH, default 3: left-shift amount applied on a scaled load; legal range 1..W-1.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_shiftsel  input  2  operation: 00 load B, 01 scaled load, 10 count down, 11 hold.
REQ-007 B  input  W  load value.
REQ-008 coarse_en  input  1  permits COARSE-sized decrements during a count op.
REQ-009 lastshift  output  1  combinational; count op is consuming the final shift.
REQ-010 rlastshift  output  1  lastshift registered one cycle.
REQ-011 step_coarse  output  1  combinational; this cycle's count op decrements by COARSE.
REQ-012 busy  output  1  registered; state is not IDLE.
REQ-013 err  output  1  registered, sticky; a count op was issued in IDLE.
REQ-014 dbg_rshcnt  output  W  current counter register rshcnt.

Function
REQ-015 Op 00 SHALL load rshcnt <= B.
REQ-016 Op 01 SHALL load rshcnt <= B[W-LOADSH-1:0] followed by LOADSH zero bits.
- With the defaults: B[1:0]=2 loads 16.
REQ-017 Op 10 SHALL decrement rshcnt according to REQ-018.
REQ-018 Count-op step size:
- By COARSE when coarse_en=1 and rshcnt >= COARSE.
- Otherwise by 1.
- Arithmetic is modulo 2^W, so 0 wraps to all ones.
REQ-019 Op 11 SHALL leave rshcnt unchanged.
REQ-020 step_coarse SHALL equal (op==10) & coarse_en & (rshcnt >= COARSE).
REQ-021 lastshift SHALL equal (op==10) & (rshcnt==0) & rst_n.
- lastshift is 0 for ops 00, 01 and 11 regardless of rshcnt.
REQ-022 A loaded value n with fine steps SHALL produce exactly n+1 count cycles.
- lastshift is high only in the last of these cycles.
REQ-023 rlastshift SHALL be lastshift delayed by exactly one clk.
REQ-024 State machine: IDLE, LOADED, RUN.
- Any op from IDLE -> LOADED on a load op (00/01).
- LOADED -> RUN on a count op.
- RUN -> IDLE on the count op with lastshift=1.
- Hold keeps the current state.
- A load in LOADED or RUN aborts and re-enters LOADED; no lastshift is produced.
REQ-025 A count op in IDLE SHALL:
- decrement rshcnt per REQ-018;
- set err=1;
- assert lastshift if rshcnt==0;
- keep the state IDLE.
REQ-026 err SHALL clear on any load op, including the same cycle a load follows an error.
REQ-027 A count op in LOADED with rshcnt==0 SHALL assert lastshift and go to IDLE directly.
REQ-028 Only the ops listed here SHALL exist. s_shiftsel is decoded every cycle, with no extra latency and no handshake beyond these ops.

Reset
REQ-029 rst_n low SHALL immediately force:
- rshcnt=0, state=IDLE, busy=0, rlastshift=0, err=0;
- lastshift=0 and step_coarse=0.
REQ-030 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high.
- No state changes while rst_n is low, whatever s_shiftsel is.

Verification (W=5, COARSE=4, LOADSH=3)
REQ-031 Fine countdown:
- Stimulus: op00 B=3, then op10 x4, coarse_en=0.
- dbg_rshcnt 3,2,1,0.
- lastshift high only in the 4th count cycle; rlastshift high the next cycle.
- rshcnt then 31; busy 1->0 after the 4th count.
REQ-032 Coarse countdown:
- Stimulus: op01 B[1:0]=2, then op10 with coarse_en=1.
- dbg_rshcnt 16,12,8,4,0.
- step_coarse high for 4 cycles; lastshift on the 5th count.
REQ-033 Hold:
- Stimulus: op00 B=0, op10 blocked by op11 x3, then op10.
- rshcnt stays 0 during hold and lastshift stays 0.
- lastshift=1 on the final op10; state ends IDLE.
REQ-034 Underflow error:
- Stimulus: op10 in IDLE after reset.
- lastshift=1, err=1, rshcnt=31, busy=0.
- A following op00 B=5 clears err and gives busy=1.
REQ-035 Abort:
- Stimulus: in RUN with rshcnt=2, op00 B=7.
- rshcnt=7, state LOADED, no lastshift/rlastshift pulse.
REQ-036 Async reset:
- Stimulus: rst_n low mid-RUN between clock edges.
- Outputs go to reset values without a clock edge.
- The first op00 B=1 after release loads 1.

Source files
------------

// File: rtl/m_shiftsequencer.sv
// Shift-count sequencer: loads a shift count (plain or scaled), counts it down
// in fine or coarse steps, and flags the final shift with a small IDLE/LOADED/RUN FSM.
module m_shiftsequencer #(
  parameter int W      = 5,
  parameter int COARSE = 4,
  parameter int LOADSH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   s_shiftsel,
  input  logic [W-1:0] B,
  input  logic         coarse_en,
  output logic         lastshift,
  output logic         rlastshift,
  output logic         step_coarse,
  output logic         busy,
  output logic         err,
  output logic [W-1:0] dbg_rshcnt
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SCALE = 2'b01;
  localparam logic [1:0] OP_COUNT = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_LOADED = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;

  localparam logic [W-1:0] COARSE_W = W'(COARSE);

  logic [W-1:0] rshcnt, rshcnt_nxt, step, scaled;
  logic [1:0]   state, state_nxt;
  logic         is_count, is_load, cnt_zero;

  assign is_count = (s_shiftsel == OP_COUNT);
  assign is_load  = (s_shiftsel == OP_LOAD) || (s_shiftsel == OP_SCALE);
  assign cnt_zero = (rshcnt == '0);

  // rst_n gating keeps both strobes low during reset independent of the op.
  assign step_coarse = is_count & coarse_en & (rshcnt >= COARSE_W) & rst_n;
  assign lastshift   = is_count & cnt_zero & rst_n;

  assign step       = step_coarse ? COARSE_W : W'(1);
  assign scaled     = {B[W-LOADSH-1:0], {LOADSH{1'b0}}};
  assign dbg_rshcnt = rshcnt;

  always_comb begin
    rshcnt_nxt = rshcnt;
    state_nxt  = state;
    case (s_shiftsel)
      OP_LOAD: begin
        rshcnt_nxt = B;
        state_nxt  = S_LOADED;
      end
      OP_SCALE: begin
        rshcnt_nxt = scaled;
        state_nxt  = S_LOADED;
      end
      OP_COUNT: begin
        // Modulo-2^W subtraction: zero wraps to all ones.
        rshcnt_nxt = rshcnt - step;
        if (state != S_IDLE)
          state_nxt = cnt_zero ? S_IDLE : S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rshcnt     <= '0;
      state      <= S_IDLE;
      busy       <= 1'b0;
      rlastshift <= 1'b0;
      err        <= 1'b0;
    end else begin
      rshcnt     <= rshcnt_nxt;
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      rlastshift <= lastshift;
      if (is_load)
        err <= 1'b0;
      else if (is_count && state == S_IDLE)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_shiftsequencer.sv
// Randomized bench for m_shiftsequencer with an arithmetic reference model
// and directed scenarios pinned to hand-computed values.
module tb_m_shiftsequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = 2'b11;
  logic [4:0] b = '0;
  logic       ce = 1'b0;
  logic       lastshift, rlastshift, step_coarse, busy, err;
  logic [4:0] dbg_rshcnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model: count value, phase (0 idle, 1 loaded, 2 running), sticky error, delayed last
  int m_cnt = 0, m_st = 0, m_err = 0, m_rlast = 0;

  m_shiftsequencer #(.W(5), .COARSE(4), .LOADSH(3)) dut (
    .clk(clk), .rst_n(rst_n), .s_shiftsel(op), .B(b), .coarse_en(ce),
    .lastshift(lastshift), .rlastshift(rlastshift), .step_coarse(step_coarse),
    .busy(busy), .err(err), .dbg_rshcnt(dbg_rshcnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_last();
    return (op == 2'b10 && m_cnt == 0 && rst_n) ? 1 : 0;
  endfunction

  function automatic int exp_coarse();
    return (op == 2'b10 && ce && m_cnt >= 4 && rst_n) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_st <= 0; m_err <= 0; m_rlast <= 0;
    end else begin
      m_rlast <= (op == 2'b10 && m_cnt == 0) ? 1 : 0;
      case (op)
        2'b00: begin m_cnt <= int'(b); m_st <= 1; m_err <= 0; end
        2'b01: begin m_cnt <= (int'(b) % 4) * 8; m_st <= 1; m_err <= 0; end
        2'b10: begin
          m_cnt <= (m_cnt - ((ce && m_cnt >= 4) ? 4 : 1) + 32) % 32;
          if (m_st == 0) m_err <= 1;
          else if (m_cnt == 0) m_st <= 0;
          else m_st <= 2;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_model();
    chk("m_lastshift", int'(lastshift), exp_last());
    chk("m_step_coarse", int'(step_coarse), exp_coarse());
    chk("m_rshcnt", int'(dbg_rshcnt), m_cnt);
    chk("m_busy", int'(busy), (m_st != 0) ? 1 : 0);
    chk("m_err", int'(err), m_err);
    chk("m_rlastshift", int'(rlastshift), m_rlast);
  endtask

  task automatic cyc(input logic [1:0] o, input logic [4:0] bv, input logic c);
    @(negedge clk);
    op = o; b = bv; ce = c;
    #1 check_model();
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_model();
    chk("reset_rshcnt", int'(dbg_rshcnt), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    // count in IDLE: wrap and error, then a load clears it
    cyc(2'b10, 5'd0, 1'b0);
    chk("idle_lastshift", int'(lastshift), 1);
    cyc(2'b11, 5'd0, 1'b0);
    chk("idle_rshcnt", int'(dbg_rshcnt), 31);
    chk("idle_err", int'(err), 1);
    chk("idle_busy", int'(busy), 0);
    cyc(2'b00, 5'd5, 1'b0);
    cyc(2'b11, 5'd0, 1'b0);
    chk("errclr_err", int'(err), 0);
    chk("errclr_busy", int'(busy), 1);
    chk("errclr_rshcnt", int'(dbg_rshcnt), 5);

    // fine countdown from 3
    cyc(2'b00, 5'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b10, 5'd0, 1'b0);
      chk("fine_rshcnt", int'(dbg_rshcnt), 3 - i);
      chk("fine_last", int'(lastshift), (i == 3) ? 1 : 0);
    end
    cyc(2'b11, 5'd0, 1'b0);
    chk("fine_rlast", int'(rlastshift), 1);
    chk("fine_wrap", int'(dbg_rshcnt), 31);
    chk("fine_busy", int'(busy), 0);

    // coarse countdown from a scaled load; upper B bits must be ignored
    cyc(2'b01, 5'b10110, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(2'b10, 5'd0, 1'b1);
      chk("coarse_rshcnt", int'(dbg_rshcnt), 16 - 4 * i);
      chk("coarse_step", int'(step_coarse), (i < 4) ? 1 : 0);
      chk("coarse_last", int'(lastshift), (i == 4) ? 1 : 0);
    end
    cyc(2'b11, 5'd0, 1'b0);
    chk("coarse_end_busy", int'(busy), 0);

    // hold with a zero count
    cyc(2'b00, 5'd0, 1'b0);
    repeat (3) begin
      cyc(2'b11, 5'd0, 1'b0);
      chk("hold_rshcnt", int'(dbg_rshcnt), 0);
      chk("hold_last", int'(lastshift), 0);
    end
    cyc(2'b10, 5'd0, 1'b0);
    chk("hold_final_last", int'(lastshift), 1);
    cyc(2'b11, 5'd0, 1'b0);
    chk("hold_end_busy", int'(busy), 0);

    // abort while running
    cyc(2'b00, 5'd4, 1'b0);
    cyc(2'b10, 5'd0, 1'b0);
    cyc(2'b10, 5'd0, 1'b0);
    cyc(2'b00, 5'd7, 1'b0);
    chk("abort_pre_rshcnt", int'(dbg_rshcnt), 2);
    chk("abort_last", int'(lastshift), 0);
    cyc(2'b11, 5'd0, 1'b0);
    chk("abort_rshcnt", int'(dbg_rshcnt), 7);
    chk("abort_rlast", int'(rlastshift), 0);
    chk("abort_busy", int'(busy), 1);

    // asynchronous reset mid-run
    cyc(2'b00, 5'd9, 1'b0);
    cyc(2'b10, 5'd0, 1'b1);
    cyc(2'b10, 5'd0, 1'b1);
    chk("prereset_coarse", int'(step_coarse), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_rshcnt", int'(dbg_rshcnt), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_coarse", int'(step_coarse), 0);
    chk("areset_last", int'(lastshift), 0);
    check_model();
    @(negedge clk);
    #1 check_model();
    chk("held_rshcnt", int'(dbg_rshcnt), 0);
    op = 2'b00; b = 5'd1; ce = 1'b0;
    rst_n = 1'b1;
    cyc(2'b11, 5'd0, 1'b0);
    chk("release_load", int'(dbg_rshcnt), 1);

    // randomized traffic weighted toward counting
    repeat (600) begin
      r = int'($urandom % 16);
      cyc((r < 9) ? 2'b10 : (r < 11) ? 2'b00 : (r < 13) ? 2'b01 : 2'b11,
          5'($urandom), 1'($urandom));
      if ($urandom % 97 == 0) begin
        #1 rst_n = 1'b0;
        #1 check_model();
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
